volume_step_controller: RTL and testbench
=========================================

VOLUME_STEP_CONTROLLER -- requirements
Module: volume_step_controller

Interface
REQ-001 SHALL have parameter DEBOUNCE_CYCLES, default 500000, consecutive stable CLK cycles for a key level to be accepted.
REQ-002 SHALL have parameter MAX_SHIFT, default 8, highest gain shift code; legal range 1..15.
REQ-003 SHALL have parameter REPEAT_CYCLES, default 12500000, auto-repeat period (used only per REQ-027).
REQ-004 SHALL have port CLK  input  1  single clock for all logic.
REQ-005 SHALL have port RESET_N  input  1  asynchronous active-low reset.
REQ-006 SHALL have port key_up_n  input  1  raw active-low volume-up key, asynchronous to CLK.
REQ-007 SHALL have port key_down_n  input  1  raw active-low volume-down key, asynchronous to CLK.
REQ-008 SHALL have port sample_strobe  input  1  one-cycle pulse per audio sample frame.
REQ-009 SHALL have port target_shift  output  4  requested gain shift code.
REQ-010 SHALL have port gain_shift  output  4  applied shift code driving the volume datapath.
REQ-011 SHALL have port at_max  output  1  target_shift == MAX_SHIFT.
REQ-012 SHALL have port at_min  output  1  target_shift == 0.
REQ-013 SHALL have port ramp_busy  output  1  gain_shift != target_shift.

Function
REQ-014 SHALL pass each key through a 2-flop synchronizer before any other use.
REQ-015 SHALL run per key a debounce FSM: RELEASED -> PRESS_WAIT (synced level low) -> HELD after DEBOUNCE_CYCLES consecutive low cycles; PRESS_WAIT -> RELEASED on any high cycle.
REQ-016 SHALL move HELD -> RELEASE_WAIT on a high level, RELEASE_WAIT -> RELEASED after DEBOUNCE_CYCLES consecutive high cycles, RELEASE_WAIT -> HELD on any low cycle.
REQ-017 SHALL emit a one-cycle press event exactly on the PRESS_WAIT -> HELD transition.
REQ-018 SHALL increment target_shift by 1 on an up event and decrement by 1 on a down event, one cycle after the event.
REQ-019 SHALL saturate: up event at MAX_SHIFT and down event at 0 leave target_shift unchanged (no wrap).
REQ-020 SHALL ignore both events when up and down events occur in the same cycle.
REQ-021 SHALL, on each sample_strobe cycle with gain_shift != target_shift, step gain_shift by exactly 1 toward target_shift, updating the following cycle.
REQ-022 SHALL hold gain_shift constant between sample_strobe pulses regardless of target changes.
REQ-023 SHALL drive at_max, at_min, ramp_busy combinationally from registered values.
REQ-024 SHALL restart a debounce count from zero whenever the qualifying level is interrupted.

Reset
REQ-025 SHALL, on RESET_N low, asynchronously force target_shift=0, gain_shift=0, at_min=1, at_max=0, ramp_busy=0, both FSMs to RELEASED, all counters and synchronizer flops to idle (high for keys).
REQ-026 SHALL discard any in-progress debounce, repeat or ramp when reset asserts mid-operation; first event after release requires a full new DEBOUNCE_CYCLES.

Configuration
REQ-027 SHALL, with macro VOLUME_AUTOREPEAT_EN defined, emit an additional press event every REPEAT_CYCLES cycles while a key stays in HELD, first one REPEAT_CYCLES after entry to HELD; repeat counter clears on leaving HELD.
REQ-028 SHALL, without VOLUME_AUTOREPEAT_EN, emit exactly one event per debounced press and omit the repeat counter logic entirely.

Verification
REQ-029 SHALL cover, with DEBOUNCE_CYCLES=4: key_up_n low 3 cycles then high -> no event, target_shift stays 0.
REQ-030 SHALL cover: 3 clean up presses, sample_strobe every 8 cycles -> target_shift=3 immediately, gain_shift steps 0->1->2->3 on successive strobes, ramp_busy low after third step.
REQ-031 SHALL cover, MAX_SHIFT=8: 10 up presses -> target_shift=8, at_max=1; one down press -> 7, at_max=0; 9 down presses -> 0, at_min=1.
REQ-032 SHALL cover: both keys debounced in the same cycle -> target_shift unchanged.
REQ-033 SHALL cover: RESET_N low mid-ramp (target=5, gain=2) -> gain_shift=0, target_shift=0 same cycle, no strobe needed.
REQ-034 SHALL cover, VOLUME_AUTOREPEAT_EN defined, REPEAT_CYCLES=16: key_up_n held 4+40 cycles -> target_shift=3 (press plus 2 repeats).

Source files
------------

// File: rtl/volume_step_controller.sv
// Volume step controller: synchronises and debounces up/down keys, keeps a target
// gain shift code, and ramps the applied shift one step per sample frame.
// Optional auto-repeat while a key is held: define VOLUME_AUTOREPEAT_EN.
module volume_step_controller #(
  parameter int DEBOUNCE_CYCLES = 500000,
  parameter int MAX_SHIFT       = 8,
  parameter int REPEAT_CYCLES   = 12500000
) (
  input  logic       CLK,
  input  logic       RESET_N,
  input  logic       key_up_n,
  input  logic       key_down_n,
  input  logic       sample_strobe,
  output logic [3:0] target_shift,
  output logic [3:0] gain_shift,
  output logic       at_max,
  output logic       at_min,
  output logic       ramp_busy
);

  typedef enum logic [1:0] {RELEASED, PRESS_WAIT, HELD, RELEASE_WAIT} key_state_e;

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int UP    = 0;
  localparam int DN    = 1;

  logic [1:0]       sync1_q, sync2_q;
  key_state_e       state_q [2];
  key_state_e       state_d [2];
  logic [CNT_W-1:0] cnt_q   [2];
  logic [CNT_W-1:0] cnt_d   [2];
  logic [1:0]       press_evt;
  logic [1:0]       key_evt;
  logic [3:0]       target_q, target_d;
  logic [3:0]       gain_q, gain_d;

  // Keys idle high, so the synchroniser resets to the released level.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      sync1_q <= 2'b11;
      sync2_q <= 2'b11;
    end else begin
      sync1_q <= {key_down_n, key_up_n};
      sync2_q <= sync1_q;
    end
  end

  // NOTE: every variable gets a default before the case so no latch is inferred.
  // The first qualifying cycle is the one that leaves RELEASED/HELD, hence count 1.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      state_d[k]   = state_q[k];
      cnt_d[k]     = cnt_q[k];
      press_evt[k] = 1'b0;
      unique case (state_q[k])
        RELEASED: if (!sync2_q[k]) begin
          state_d[k] = PRESS_WAIT;
          cnt_d[k]   = CNT_W'(1);
        end
        PRESS_WAIT: if (sync2_q[k]) begin
          state_d[k] = RELEASED;
          cnt_d[k]   = '0;
        end else if (cnt_q[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          state_d[k]   = HELD;
          cnt_d[k]     = '0;
          press_evt[k] = 1'b1;
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
        HELD: if (sync2_q[k]) begin
          state_d[k] = RELEASE_WAIT;
          cnt_d[k]   = CNT_W'(1);
        end
        RELEASE_WAIT: if (!sync2_q[k]) begin
          state_d[k] = HELD;
          cnt_d[k]   = '0;
        end else if (cnt_q[k] == CNT_W'(DEBOUNCE_CYCLES - 1)) begin
          state_d[k] = RELEASED;
          cnt_d[k]   = '0;
        end else begin
          cnt_d[k] = cnt_q[k] + CNT_W'(1);
        end
        default: begin
          state_d[k] = RELEASED;
          cnt_d[k]   = '0;
        end
      endcase
    end
  end

  // NOTE: state arrays are small control registers, so they take the async reset too.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int k = 0; k < 2; k++) begin
        state_q[k] <= RELEASED;
        cnt_q[k]   <= '0;
      end
    end else begin
      for (int k = 0; k < 2; k++) begin
        state_q[k] <= state_d[k];
        cnt_q[k]   <= cnt_d[k];
      end
    end
  end

`ifdef VOLUME_AUTOREPEAT_EN
  localparam int RPT_W = $clog2(REPEAT_CYCLES + 1);

  logic [RPT_W-1:0] rpt_q [2];
  logic [RPT_W-1:0] rpt_d [2];
  logic [1:0]       rpt_evt;

  // Counting starts on the first cycle spent in HELD and stops the moment HELD is left.
  always_comb begin
    for (int k = 0; k < 2; k++) begin
      rpt_d[k]   = '0;
      rpt_evt[k] = 1'b0;
      if (state_q[k] == HELD && state_d[k] == HELD) begin
        if (rpt_q[k] == RPT_W'(REPEAT_CYCLES - 1)) begin
          rpt_evt[k] = 1'b1;
        end else begin
          rpt_d[k] = rpt_q[k] + RPT_W'(1);
        end
      end
    end
  end

  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      for (int k = 0; k < 2; k++) rpt_q[k] <= '0;
    end else begin
      for (int k = 0; k < 2; k++) rpt_q[k] <= rpt_d[k];
    end
  end

  assign key_evt = press_evt | rpt_evt;
`else
  assign key_evt = press_evt;
`endif

  // Simultaneous up and down cancel each other.
  always_comb begin
    target_d = target_q;
    if (key_evt[UP] && !key_evt[DN] && target_q != 4'(MAX_SHIFT)) begin
      target_d = target_q + 4'd1;
    end else if (key_evt[DN] && !key_evt[UP] && target_q != 4'd0) begin
      target_d = target_q - 4'd1;
    end
  end

  always_comb begin
    gain_d = gain_q;
    if (sample_strobe && gain_q != target_q) begin
      gain_d = (gain_q < target_q) ? gain_q + 4'd1 : gain_q - 4'd1;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together.
  always_ff @(posedge CLK or negedge RESET_N) begin
    if (!RESET_N) begin
      target_q <= 4'd0;
      gain_q   <= 4'd0;
    end else begin
      target_q <= target_d;
      gain_q   <= gain_d;
    end
  end

  assign target_shift = target_q;
  assign gain_shift   = gain_q;
  assign at_max       = (target_q == 4'(MAX_SHIFT));
  assign at_min       = (target_q == 4'd0);
  assign ramp_busy    = (gain_q != target_q);

endmodule

// File: tb/tb_volume_step_controller.sv
// Scoreboard bench for volume_step_controller: directed key/strobe stimulus pushes
// expected (target, gain) pairs; a monitor pops one on every output change.
module tb_volume_step_controller;

  localparam int DEB = 4;
  localparam int MAX = 8;
  localparam int RPT = 16;

  logic       clk;
  logic       rst_n;
  logic       key_up_n;
  logic       key_down_n;
  logic       sample_strobe;
  logic [3:0] target_shift;
  logic [3:0] gain_shift;
  logic       at_max;
  logic       at_min;
  logic       ramp_busy;

  volume_step_controller #(
    .DEBOUNCE_CYCLES(DEB),
    .MAX_SHIFT      (MAX),
    .REPEAT_CYCLES  (RPT)
  ) dut (
    .CLK          (clk),
    .RESET_N      (rst_n),
    .key_up_n     (key_up_n),
    .key_down_n   (key_down_n),
    .sample_strobe(sample_strobe),
    .target_shift (target_shift),
    .gain_shift   (gain_shift),
    .at_max       (at_max),
    .at_min       (at_min),
    .ramp_busy    (ramp_busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] t;
    logic [3:0] g;
  } exp_t;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  task automatic push(input int t, input int g);
    exp_t e;
    e.t = 4'(t);
    e.g = 4'(g);
    exp_q.push_back(e);
  endtask

  // Monitor: any change of the registered outputs must match the next expectation.
  logic [7:0] prev_out = 8'h00;
  always @(negedge clk) begin
    logic [7:0] cur;
    exp_t       e;
    cur = {target_shift, gain_shift};
    if (cur !== prev_out) begin
      if (exp_q.size() == 0) begin
        check("unexpected_change", cur, prev_out);
      end else begin
        e = exp_q.pop_front();
        check("target_shift", 8'(target_shift), 8'(e.t));
        check("gain_shift",   8'(gain_shift),   8'(e.g));
        check("at_max",    8'(at_max),    8'(e.t == 4'(MAX)));
        check("at_min",    8'(at_min),    8'(e.t == 4'd0));
        check("ramp_busy", 8'(ramp_busy), 8'(e.t != e.g));
      end
      prev_out = cur;
    end
  end

  // Inputs change 2 ns after the rising edge; outputs are sampled on the falling edge.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  task automatic press(input bit up, input bit dn, input int low_cycles);
    key_up_n   = ~up;
    key_down_n = ~dn;
    tick(low_cycles);
    key_up_n   = 1'b1;
    key_down_n = 1'b1;
    tick(10);
  endtask

  task automatic strobe();
    sample_strobe = 1'b1;
    tick(1);
    sample_strobe = 1'b0;
    tick(7);
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    tick(3);
    rst_n = 1'b1;
    tick(2);
  endtask

  initial begin
    rst_n         = 1'b0;
    key_up_n      = 1'b1;
    key_down_n    = 1'b1;
    sample_strobe = 1'b0;
    tick(3);
    check("rst_target",  8'(target_shift), 8'd0);
    check("rst_gain",    8'(gain_shift),   8'd0);
    check("rst_at_min",  8'(at_min),       8'd1);
    check("rst_at_max",  8'(at_max),       8'd0);
    check("rst_busy",    8'(ramp_busy),    8'd0);
    rst_n = 1'b1;
    tick(2);

    // Three low cycles is one short of the debounce window.
    key_up_n = 1'b0;
    tick(3);
    key_up_n = 1'b1;
    tick(12);
    check("glitch_target", 8'(target_shift), 8'd0);

    for (int i = 1; i <= 3; i++) begin
      push(i, 0);
      press(1'b1, 1'b0, 8);
    end

    for (int i = 1; i <= 3; i++) begin
      push(3, i);
      strobe();
    end
    strobe();
    check("ramp_done_busy", 8'(ramp_busy), 8'd0);

    press(1'b1, 1'b1, 8);
    check("both_keys_target", 8'(target_shift), 8'd3);

    for (int i = 4; i <= 10; i++) begin
      if (i <= MAX) push(i, 3);
      press(1'b1, 1'b0, 8);
    end
    check("sat_max_target", 8'(target_shift), 8'(MAX));
    check("sat_max_flag",   8'(at_max),       8'd1);

    push(7, 3);
    press(1'b0, 1'b1, 8);
    for (int i = 6; i >= -2; i--) begin
      if (i >= 0) push(i, 3);
      press(1'b0, 1'b1, 8);
    end
    check("sat_min_target", 8'(target_shift), 8'd0);
    check("sat_min_flag",   8'(at_min),       8'd1);

    for (int i = 2; i >= 0; i--) begin
      push(0, i);
      strobe();
    end

    // Build target=5, gain=2, then reset without any strobe.
    for (int i = 1; i <= 5; i++) begin
      push(i, 0);
      press(1'b1, 1'b0, 8);
    end
    push(5, 1);
    strobe();
    push(5, 2);
    strobe();
    push(0, 0);
    rst_n = 1'b0;
    #1;
    check("midramp_rst_target", 8'(target_shift), 8'd0);
    check("midramp_rst_gain",   8'(gain_shift),   8'd0);
    check("midramp_rst_at_min", 8'(at_min),       8'd1);
    tick(3);
    rst_n = 1'b1;
    tick(2);
    push(1, 0);
    press(1'b1, 1'b0, 8);
    push(1, 1);
    strobe();

    // Long hold: one press, plus two repeats when auto-repeat is built in.
    push(0, 0);
    do_reset();
    push(1, 0);
`ifdef VOLUME_AUTOREPEAT_EN
    push(2, 0);
    push(3, 0);
`endif
    press(1'b1, 1'b0, 44);
`ifdef VOLUME_AUTOREPEAT_EN
    check("hold_target", 8'(target_shift), 8'd3);
`else
    check("hold_target", 8'(target_shift), 8'd1);
`endif

    tick(20);
    check("queue_drained", 8'(exp_q.size()), 8'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
